eth_phy_10g_tx_gearbox: RTL and testbench
=========================================

# eth_phy_10g_tx_gearbox

Transmit-side 64b/66b PHY block: takes one 64-bit block plus 2-bit sync header per accepted transfer, optionally scrambles the payload (x^58 + x^39 + 1 self-synchronous), and packs 66-bit frames into a continuous 64-bit SERDES word stream. It sits between the PCS encoder and the SERDES TX port. It is the mirror of the RX frame aligner: its output, looped back, must reach block lock with zero bitslips.

## Interface
- DATA_WIDTH, 64, payload width; only 64 supported
- HDR_WIDTH, 2, sync header width
- SCRAMBLER_BYPASS, 0, 1 = payload passes unscrambled
- clk  input  1  single clock, every edge produces one SERDES word
- rst_n  input  1  asynchronous, active-low reset
- i_tx_data  input  64  block payload, bit 0 transmitted first
- i_tx_hdr  input  2  sync header, bit 0 transmitted first; never scrambled, never checked
- i_tx_valid  input  1  block present on i_tx_data/i_tx_hdr
- o_tx_ready  output  1  block consumed on this edge if asserted
- o_serdes_tx  output  64  SERDES word, bit 0 transmitted first

## Operation
- Frame F[65:0] = {scr(i_tx_data), i_tx_hdr}; header occupies F[1:0].
- Sequence counter seq 0..32, wraps 32 -> 0; holds 0 in reset.
- seq 0..31: o_tx_ready = 1; a block slot is consumed every cycle whether or not i_tx_valid is high.
  - valid high: frame built from inputs.
  - valid low (underflow): idle control block inserted: hdr 2'b10, payload 64'h0000_0000_0000_001E (block type 0x1E, idle), scrambled like any payload.
- seq 32: o_tx_ready = 0, no block consumed, scrambler holds state.
- Residue buffer R holds exactly 2*seq bits. Consuming slot: C = {F, R[2*seq-1:0]}; word = C[63:0]; R <= C[2*seq+65:64]. At seq 32 word = R[63:0], R emptied.
- Scrambler: 58-bit state S, reset 58'h3FF_FFFF_FFFF_FFFF. Per payload bit i (LSB first): out = d ^ S[38] ^ S[57]; S <= {S[56:0], out}. All 64 bits per cycle combinationally unrolled. Bypass: out = d, S unchanged.
- i_tx_valid high while o_tx_ready low: block not consumed; upstream must hold it (standard ready/valid). Data/hdr may change only after consumption.

## Timing
- Reset values: o_serdes_tx = 64'h0, o_tx_ready = 0, seq = 0, R empty, S = seed.
- o_tx_ready is combinational from seq gated by a started flag; started clears in reset and sets on first clk edge after rst_n deasserts, so ready is high in the first post-reset cycle.
- o_serdes_tx registered; latency from accepting edge to word containing that frame's header: 1 cycle. First post-reset word carries frame 0 bits [63:0].
- Period: 33 cycles, 32 blocks, 33 words; ready low exactly 1 cycle in 33.
- Reset assertion mid-sequence: immediate clear of all state; partially sent frame discarded; restart at seq 0.

## Structure
- Shared package/include eth_phy_10g_pkg: SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10, BLOCK_TYPE_IDLE = 8'h1E, SCR_SEED (58 bits), GB_SEQ_LAST = 32; reused by RX aligner and descrambler.
- Sub-module eth_phy_10g_tx_scrambler: 64-bit combinational unroll plus state register with enable (enable = slot consumed and not bypass).
- Top: seq counter, residue buffer (≤130-bit concatenation), idle insertion mux, output register.

## Test plan
- Reset release, SCRAMBLER_BYPASS=1, i_tx_valid=1, hdr 2'b01, data 64'hFFFF_FFFF_FFFF_FFFF constant -> first word 64'hFFFF_FFFF_FFFF_FFFD; ready low on cycle 33 and every 33rd cycle; 33 words hold exactly 32 "01" headers at bit offsets 66k.
- Bypass, data 64'h0, hdr 2'b10, valid stuck low -> stream equals repeated idle frame {64'h1E, 2'b10} packed; word 0 = 64'h0000_0000_0000_007A.
- Scrambler on, data all-zero, hdr 01 -> payload equals reference LFSR sequence from SCR_SEED; descrambler model recovers 64'h0 for every block.
- Loopback into RX frame aligner with pattern set {FF.., 00.., 55.., AA.., FE.., 07..} -> o_rx_block_lock asserts, zero bitslip pulses required, recovered data/hdr match sent.
- Valid toggling 1,0,1,0 across the seq-32 boundary -> held block at ready-low cycle consumed on next cycle, idles fill valid-low slots, no block lost or duplicated.
- rst_n asserted at seq 17 for 3 cycles -> o_serdes_tx = 0, o_tx_ready = 0 immediately; after release sequence restarts with seq 0, scrambler from seed.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10GBASE-R PHY constants: sync headers, idle block type, scrambler seed, gearbox period.
package eth_phy_10g_pkg;

    typedef enum logic [1:0] {
        SYNC_DATA = 2'b01,
        SYNC_CTRL = 2'b10
    } sync_hdr_e;

    localparam logic [7:0]  BLOCK_TYPE_IDLE = 8'h1E;
    localparam logic [57:0] SCR_SEED        = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [5:0]  GB_SEQ_LAST     = 6'd32;

    localparam logic [63:0] IDLE_PAYLOAD = {56'h0, BLOCK_TYPE_IDLE};

endpackage

// File: rtl/eth_phy_10g_tx_scrambler.sv
// Self-synchronous x^58 + x^39 + 1 scrambler, 64 bits per clock, LSB first.
module eth_phy_10g_tx_scrambler
    import eth_phy_10g_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);

    logic [57:0] state_q, state_d;
    logic [57:0] s_walk;
    logic        s_bit;

    always_comb begin
        s_walk = state_q;
        s_bit  = 1'b0;
        o_data = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            s_bit     = i_data[i] ^ s_walk[38] ^ s_walk[57];
            o_data[i] = s_bit;
            s_walk    = {s_walk[56:0], s_bit};
        end
        state_d = i_en ? s_walk : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 64b/66b TX gearbox: scrambles blocks, inserts idles on underflow, packs 66-bit frames into 64-bit words.
module eth_phy_10g_tx_gearbox
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int HDR_WIDTH        = 2,
    parameter int SCRAMBLER_BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [63:0]           o_serdes_tx
);

    logic        started_q, started_d;
    logic [5:0]  seq_q, seq_d;
    logic [63:0] res_q, res_d;
    logic [63:0] word_q, word_d;

    logic         slot;
    logic [63:0]  payload;
    logic [1:0]   hdr;
    logic [63:0]  scr_out;
    logic [65:0]  frame;
    logic [127:0] cat;

    assign slot        = started_q && (seq_q != GB_SEQ_LAST);
    assign o_tx_ready  = slot;
    assign o_serdes_tx = word_q;

    eth_phy_10g_tx_scrambler u_scrambler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (slot && (SCRAMBLER_BYPASS == 0)),
        .i_data (payload),
        .o_data (scr_out)
    );

    always_comb begin
        payload   = i_tx_valid ? i_tx_data : IDLE_PAYLOAD;
        hdr       = i_tx_valid ? i_tx_hdr  : SYNC_CTRL;
        frame     = {(SCRAMBLER_BYPASS != 0) ? payload : scr_out, hdr};
        // Residue bits above 2*seq are always zero, so OR-merge replaces an explicit mask.
        cat       = ({62'h0, frame} << {seq_q, 1'b0}) | {64'h0, res_q};
        started_d = 1'b1;
        seq_d     = seq_q;
        res_d     = res_q;
        word_d    = word_q;
        if (started_q) begin
            if (slot) begin
                word_d = cat[63:0];
                res_d  = cat[127:64];
                seq_d  = seq_q + 6'd1;
            end else begin
                word_d = res_q;
                res_d  = '0;
                seq_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            seq_q     <= '0;
            res_q     <= '0;
            word_q    <= '0;
        end else begin
            started_q <= started_d;
            seq_q     <= seq_d;
            res_q     <= res_d;
            word_q    <= word_d;
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Bench for the TX gearbox: scrambled and bypass instances checked against a bit-stream reference model.
module tb_eth_phy_10g_tx_gearbox;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] tx_data = '0;
    logic [1:0]  tx_hdr = 2'b01;
    logic        tx_valid = 1'b0;
    logic        rdy_s, rdy_b;
    logic [63:0] ser_s, ser_b;

    always #5 clk = ~clk;

    eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .SCRAMBLER_BYPASS(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(rdy_s), .o_serdes_tx(ser_s)
    );

    eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .SCRAMBLER_BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(rdy_b), .o_serdes_tx(ser_b)
    );

    int unsigned total = 0;
    int unsigned passed = 0;

    // Reference: transmitted bit stream as queues, scrambler as history of scrambled bits.
    bit          q_s[$];
    bit          q_b[$];
    bit          hist[$];
    logic [63:0] exp_s, exp_b;
    bit          m_started;
    int          m_cnt;
    bit          held;
    int          ready_lows;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic bit m_ready();
        return m_started && (m_cnt != 32);
    endfunction

    function automatic void model_reset();
        q_s.delete();
        q_b.delete();
        hist.delete();
        repeat (58) hist.push_back(1'b1);
        m_started = 1'b0;
        m_cnt     = 0;
        exp_s     = '0;
        exp_b     = '0;
        held      = 1'b0;
    endfunction

    // Output bit = data ^ scrambled bit 39 ago ^ scrambled bit 58 ago; history starts all ones.
    function automatic logic [63:0] scramble(input logic [63:0] d);
        logic [63:0] r;
        bit o;
        for (int i = 0; i < 64; i++) begin
            o = d[i] ^ hist[19] ^ hist[0];
            r[i] = o;
            hist.push_back(o);
            void'(hist.pop_front());
        end
        return r;
    endfunction

    function automatic void model_edge();
        logic [63:0] d, sd;
        logic [1:0]  h;
        if (!m_started) begin
            m_started = 1'b1;
            held      = 1'b0;
            return;
        end
        held = tx_valid && (m_cnt == 32);
        if (m_cnt != 32) begin
            d  = tx_valid ? tx_data : 64'h1E;
            h  = tx_valid ? tx_hdr  : 2'b10;
            sd = scramble(d);
            for (int i = 0; i < 2; i++) begin
                q_s.push_back(h[i]);
                q_b.push_back(h[i]);
            end
            for (int i = 0; i < 64; i++) begin
                q_s.push_back(sd[i]);
                q_b.push_back(d[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            exp_s[i] = q_s.pop_front();
            exp_b[i] = q_b.pop_front();
        end
        m_cnt = (m_cnt == 32) ? 0 : m_cnt + 1;
    endfunction

    // Called at a negedge: drive inputs, take one clock edge, check outputs at the next negedge.
    task automatic step(input int mode);
        if (!held) begin
            case (mode)
                0: begin tx_valid = 1'b1; tx_data = 64'hFFFF_FFFF_FFFF_FFFF; tx_hdr = 2'b01; end
                1: begin tx_valid = 1'b0; tx_data = 64'h0; tx_hdr = 2'b10; end
                2: begin tx_valid = 1'b1; tx_data = 64'h0; tx_hdr = 2'b01; end
                3: begin
                    tx_valid = ($urandom_range(0, 3) != 0);
                    tx_data  = {$urandom, $urandom};
                    tx_hdr   = 2'($urandom_range(0, 3));
                end
                default: begin
                    tx_valid = ~tx_valid;
                    tx_data  = {$urandom, $urandom};
                    tx_hdr   = 2'($urandom_range(0, 3));
                end
            endcase
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ready_scr", {63'h0, rdy_s}, {63'h0, m_ready()});
        chk("ready_byp", {63'h0, rdy_b}, {63'h0, m_ready()});
        chk("word_scr", ser_s, exp_s);
        chk("word_byp", ser_b, exp_b);
        if (rdy_b === 1'b0) ready_lows++;
    endtask

    // Asserts reset mid-cycle, checks immediate clear, holds three edges, releases on a negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_word_scr"}, ser_s, 64'h0);
        chk({tag, "_word_byp"}, ser_b, 64'h0);
        chk({tag, "_ready"}, {62'h0, rdy_s, rdy_b}, 64'h0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_held_word"}, ser_s, 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("por");

        // Bypass, constant all-ones data with data header.
        ready_lows = 0;
        step(0);
        chk("first_ready_high", {63'h0, rdy_b}, 64'h1);
        step(0);
        chk("ff_first_word", ser_b, 64'hFFFF_FFFF_FFFF_FFFD);
        ready_lows = 0;
        for (int i = 0; i < 66; i++) step(0);
        chk("ready_low_count", 64'(ready_lows), 64'd2);

        // Underflow: idle control blocks only.
        do_reset("rst_idle");
        step(1);
        step(1);
        chk("idle_first_word", ser_b, 64'h0000_0000_0000_007A);
        for (int i = 0; i < 40; i++) step(1);

        // Scrambler running on all-zero payload.
        do_reset("rst_zero");
        for (int i = 0; i < 70; i++) step(2);

        // Alternating valid across several ready-low cycles.
        do_reset("rst_alt");
        tx_valid = 1'b0;
        for (int i = 0; i < 80; i++) step(4);

        // Random traffic, then reset at seq 17 and restart from seed.
        do_reset("rst_rand");
        for (int i = 0; i < 60 && m_cnt != 17; i++) step(3);
        chk("reached_seq17", 64'(m_cnt), 64'd17);
        do_reset("rst_seq17");
        for (int i = 0; i < 200; i++) step(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
